// File: rtl/makehint_ctrl.sv
// makehint_ctrl: sequencer for the hint-generation datapath of the signing loop.
// Streams K polynomials (four coefficients per beat) from two coefficient RAM
// banks into the hint unit, waits for its reject decision, then drains the
// packed hint words into the signature buffer starting at a programmable address.
//
// Optional build macro MAKEHINT_CTRL_SIGBP_EN adds a sig_ready input that lets
// the signature RAM stall the unload phase.
//
// Handshake rule for the hint word path: a word moves on a cycle where both
// hint_valid_i and hint_ready_o are high; that same cycle writes it to the
// signature RAM. hint_valid_i may rise or fall freely; hint_ready_o is only
// high in UNLOAD, while no reject is pending and the signature RAM can accept.
module makehint_ctrl #(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 24,
    parameter int W        = 64,
    parameter int RADDR_W  = 9,
    parameter int SADDR_W  = 8,
    parameter int DRAIN    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [2:0]                  sec_lvl,
    input  logic [SADDR_W-1:0]          sig_base,
    output logic                        rd_en,
    output logic [RADDR_W-1:0]          rd_addr,
    input  logic [OUTPUT_W*COEFF_W-1:0] rd_data0,
    input  logic [OUTPUT_W*COEFF_W-1:0] rd_data1,
    output logic [OUTPUT_W*COEFF_W-1:0] poly0_o,
    output logic [OUTPUT_W*COEFF_W-1:0] poly1_o,
    output logic                        poly_valid_o,
    input  logic [W-1:0]                hint_i,
    input  logic                        hint_valid_i,
    output logic                        hint_ready_o,
    input  logic                        reject_i,
    output logic                        hu_rst,
`ifdef MAKEHINT_CTRL_SIGBP_EN
    input  logic                        sig_ready,
`endif
    output logic                        sig_we,
    output logic [SADDR_W-1:0]          sig_addr,
    output logic [W-1:0]                sig_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        reject,
    output logic [2:0]                  dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam int DCNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int WCNT_W = 4;

    logic [2:0]         state_q;
    logic [2:0]         lvl_q;
    logic [SADDR_W-1:0] base_q;
    logic [RADDR_W-1:0] beat_q;
    logic [WCNT_W-1:0]  word_q;
    logic [DCNT_W-1:0]  drain_q;
    logic               rej_q;
    logic               pvalid_q;

    logic               sig_rdy;
    logic               hs;
    logic [RADDR_W-1:0] last_beat;
    logic [WCNT_W-1:0]  last_word;
    int                 k_polys;

`ifdef MAKEHINT_CTRL_SIGBP_EN
    assign sig_rdy = sig_ready;
`else
    assign sig_rdy = 1'b1;
`endif

    // Per-level geometry from the latched security level; unknown levels run as level 5.
    always_comb begin
        k_polys   = 8;
        last_word = WCNT_W'(10);
        case (lvl_q)
            3'd2: begin k_polys = 4; last_word = WCNT_W'(10); end
            3'd3: begin k_polys = 6; last_word = WCNT_W'(7);  end
            default: begin k_polys = 8; last_word = WCNT_W'(10); end
        endcase
        last_beat = RADDR_W'(k_polys * 64 - 1);
    end

    // Handshake and datapath outputs, all derived from the current state.
    always_comb begin
        hint_ready_o = (state_q == S_UNLOAD) && !reject_i && sig_rdy;
        hs           = hint_ready_o && hint_valid_i;
        rd_en        = (state_q == S_FETCH);
        rd_addr      = rd_en ? beat_q : '0;
        hu_rst       = (state_q == S_CLR);
        sig_we       = hs;
        sig_addr     = hs ? (base_q + SADDR_W'(word_q)) : '0;
        sig_wdata    = hs ? hint_i : '0;
        poly_valid_o = pvalid_q;
        poly0_o      = pvalid_q ? rd_data0 : '0;
        poly1_o      = pvalid_q ? rd_data1 : '0;
        busy         = (state_q == S_CLR) || (state_q == S_FETCH) ||
                       (state_q == S_DRAIN) || (state_q == S_UNLOAD);
        done         = (state_q == S_FIN) && !rej_q;
        reject       = (state_q == S_FIN) && rej_q;
        dbg_state    = state_q;
    end

    // Beat-valid tracks the one-cycle RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pvalid_q <= 1'b0;
        else     pvalid_q <= rd_en;
    end

    // Sequencer: state, latched job parameters and phase counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lvl_q   <= '0;
            base_q  <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            drain_q <= '0;
            rej_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLR;
                        lvl_q   <= sec_lvl;
                        base_q  <= sig_base;
                        rej_q   <= 1'b0;
                    end
                end
                S_CLR: begin
                    state_q <= S_FETCH;
                    beat_q  <= '0;
                end
                S_FETCH: begin
                    // A reject abandons the stream at once; the in-flight beat is harmless.
                    if (reject_i) begin
                        state_q <= S_FIN;
                        rej_q   <= 1'b1;
                    end else if (beat_q == last_beat) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Give the hint unit time to finish before trusting its reject flag.
                    if (drain_q == DCNT_W'(DRAIN - 1)) begin
                        word_q <= '0;
                        if (reject_i) begin
                            state_q <= S_FIN;
                            rej_q   <= 1'b1;
                        end else begin
                            state_q <= S_UNLOAD;
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (reject_i) begin
                        state_q <= S_FIN;
                        rej_q   <= 1'b1;
                    end else if (hs) begin
                        word_q <= word_q + 1'b1;
                        if (word_q == last_word) state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_makehint_ctrl.sv
// Bench for makehint_ctrl: table of directed jobs, hand-written reset and
// start-while-busy sequences, then randomized jobs checked against a
// job-level model of reads, writes, outcome and latency.
`timescale 1ns/1ps
module tb_makehint_ctrl;
  localparam int OW = 4;
  localparam int CW = 24;
  localparam int W  = 64;
  localparam int RW = 9;
  localparam int SW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [2:0]        sec_lvl = '0;
  logic [SW-1:0]     sig_base = '0;
  logic              rd_en;
  logic [RW-1:0]     rd_addr;
  logic [OW*CW-1:0]  rd_data0, rd_data1;
  logic [OW*CW-1:0]  poly0_o, poly1_o;
  logic              poly_valid_o;
  logic [W-1:0]      hint_i = '0;
  logic              hint_valid_i = 1'b0;
  logic              hint_ready_o;
  logic              reject_i = 1'b0;
  logic              hu_rst;
  logic              sig_ready = 1'b1;
  logic              sig_we;
  logic [SW-1:0]     sig_addr;
  logic [W-1:0]      sig_wdata;
  logic              busy, done, reject;
  logic [2:0]        dbg_state;

  makehint_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sec_lvl(sec_lvl), .sig_base(sig_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .poly0_o(poly0_o), .poly1_o(poly1_o), .poly_valid_o(poly_valid_o),
    .hint_i(hint_i), .hint_valid_i(hint_valid_i), .hint_ready_o(hint_ready_o),
    .reject_i(reject_i), .hu_rst(hu_rst),
`ifdef MAKEHINT_CTRL_SIGBP_EN
    .sig_ready(sig_ready),
`endif
    .sig_we(sig_we), .sig_addr(sig_addr), .sig_wdata(sig_wdata),
    .busy(busy), .done(done), .reject(reject), .dbg_state(dbg_state)
  );

  // coefficient RAM model: data is a function of the address read
  bit zero_coef = 1'b0;
  logic [RW-1:0] ram_addr_q = '0;
  always @(posedge clk) if (rd_en) ram_addr_q <= rd_addr;

  function automatic logic [OW*CW-1:0] coef(input logic [RW-1:0] a, input bit bank);
    logic [CW-1:0] c;
    c = {bank, 14'h1a5, a};
    return zero_coef ? '0 : {OW{c}};
  endfunction
  assign rd_data0 = coef(ram_addr_q, 1'b0);
  assign rd_data1 = coef(ram_addr_q, 1'b1);

  // counters and check helper
  int n_tests = 0;
  int n_fail  = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] exp_a_q[$];

  // per-job observations
  bit mon_on = 1'b0;
  int cyc = 0;
  bit hs = 1'b0;
  int rd_cnt, rd_bad, poly_bad, hu_cnt, hu_bad, wr_cnt, wr_bad, busy_bad, pulses;
  bit fin_seen, fin_rej, fin_done;
  int fin_cyc;
  bit prev_rd;
  logic [RW-1:0] prev_addr;

  always @(negedge clk) begin
    if (mon_on) begin
      hs = hint_valid_i && hint_ready_o;
      if (rd_en) begin
        if (rd_addr != RW'(rd_cnt) || cyc != rd_cnt + 2) rd_bad++;
        rd_cnt++;
      end
      if (poly_valid_o != prev_rd) poly_bad++;
      else if (prev_rd && (poly0_o != coef(prev_addr, 1'b0) || poly1_o != coef(prev_addr, 1'b1)))
        poly_bad++;
      prev_rd   = rd_en;
      prev_addr = rd_addr;
      if (hu_rst) begin
        hu_cnt++;
        if (cyc != 1) hu_bad++;
      end
      if (sig_we) begin
        wr_cnt++;
`ifdef MAKEHINT_CTRL_SIGBP_EN
        if (!sig_ready) wr_bad++;
`endif
        if (exp_q.size() > 0) begin
          check("wr_addr", 64'(sig_addr), 64'(exp_a_q.pop_front()));
          check("wr_data", sig_wdata, exp_q.pop_front());
        end
      end
      if (done || reject) begin
        pulses++;
        if (!fin_seen) begin
          fin_seen = 1'b1;
          fin_cyc  = cyc;
          fin_rej  = reject;
          fin_done = done;
        end
      end
      if (cyc == 0 && busy) busy_bad++;
      else if (!fin_seen && cyc >= 1 && !busy) busy_bad++;
      else if (fin_seen && busy) busy_bad++;
    end
  end

  // job description: stimulus plus expected results
  typedef struct {
    logic [2:0]    lvl;
    logic [SW-1:0] base;
    int            mode;     // 0 clean, 1 reject in FETCH, 2 reject in DRAIN, 3 reject in UNLOAD
    int            rej_cyc;  // cycle (start = 0) at which reject_i rises
    bit            zero;
    bit            xstart;   // extra start pulse during FETCH
    int            reads;
    int            writes;
    bit            rej;
    int            end_cyc;  // -1: not checked
  } vec_t;

  // job-level reference: geometry by level and the latency of each outcome
  function automatic vec_t model(input logic [2:0] lvl, input logic [SW-1:0] base,
                                 input int mode, input int b);
    vec_t v;
    int k, nw, nb;
    k  = (lvl == 3'd2) ? 4 : (lvl == 3'd3) ? 6 : 8;
    nw = (lvl == 3'd3) ? 8 : 11;
    nb = 64 * k;
    v.lvl = lvl; v.base = base; v.mode = mode; v.zero = 1'b0; v.xstart = 1'b0;
    v.rej_cyc = 0;
    case (mode)
      1: begin
        b = b % nb;
        v.rej_cyc = 2 + b; v.reads = b + 1; v.writes = 0; v.rej = 1'b1; v.end_cyc = b + 3;
      end
      2: begin
        v.rej_cyc = nb + 3; v.reads = nb; v.writes = 0; v.rej = 1'b1; v.end_cyc = nb + 5;
      end
      default: begin
        v.reads = nb; v.writes = nw; v.rej = 1'b0; v.end_cyc = 1 + nb + 3 + nw + 1;
      end
    endcase
    return v;
  endfunction

  logic [W-1:0] words[16];

  // driver: one complete job from start pulse to a few cycles after done/reject
  task automatic run(input vec_t v, input bit rnd_valid, input bit bp, input string tag);
    int idx;
    zero_coef = v.zero;
    exp_q.delete();
    exp_a_q.delete();
    for (int i = 0; i < 16; i++) words[i] = v.zero ? W'(i) : {$urandom, $urandom};
    for (int i = 0; i < v.writes; i++) begin
      exp_a_q.push_back(v.base + SW'(i));
      exp_q.push_back(words[i]);
    end
    rd_cnt = 0; rd_bad = 0; poly_bad = 0; hu_cnt = 0; hu_bad = 0; wr_cnt = 0; wr_bad = 0;
    busy_bad = 0; pulses = 0; fin_seen = 0; fin_rej = 0; fin_done = 0; fin_cyc = 0;
    prev_rd = 0; prev_addr = '0; hs = 0; idx = 0;
    @(posedge clk); #1;
    cyc = 0; start = 1'b1; sec_lvl = v.lvl; sig_base = v.base;
    hint_valid_i = 1'b0; hint_i = words[0]; reject_i = 1'b0; sig_ready = 1'b1;
    mon_on = 1'b1;
    while (!(fin_seen && cyc >= fin_cyc + 3) && cyc < 700) begin
      @(posedge clk); #1;
      cyc++;
      start = v.xstart && (cyc == 100);
      if (start) begin sec_lvl = 3'd5; sig_base = ~v.base; end
      if (hs) idx++;
      hint_valid_i = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      hint_i = words[idx & 15];
      reject_i = (v.mode != 0) && (cyc >= v.rej_cyc);
      sig_ready = bp ? (cyc % 3 == 0) : 1'b1;
    end
    mon_on = 1'b0;
    start = 1'b0; reject_i = 1'b0; hint_valid_i = 1'b0; sig_ready = 1'b1;
    check({tag, "_finished"}, 64'(fin_seen), 64'd1);
    if (v.end_cyc >= 0) check({tag, "_end_cycle"}, 64'(fin_cyc), 64'(v.end_cyc));
    check({tag, "_reject"}, 64'(fin_rej), 64'(v.rej));
    check({tag, "_done"}, 64'(fin_done), 64'(!v.rej));
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_reads"}, 64'(rd_cnt), 64'(v.reads));
    check({tag, "_read_order"}, 64'(rd_bad), 64'd0);
    check({tag, "_poly"}, 64'(poly_bad), 64'd0);
    check({tag, "_hu_rst"}, 64'(hu_cnt), 64'd1);
    check({tag, "_hu_rst_cycle"}, 64'(hu_bad), 64'd0);
    check({tag, "_writes"}, 64'(wr_cnt), 64'(v.writes));
    check({tag, "_write_gate"}, 64'(wr_bad), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_idle"}, 64'(dbg_state), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({busy, rd_en, poly_valid_o, hint_ready_o, hu_rst, sig_we, done, reject}), 64'd0);
    check({tag, "_addr"}, 64'({rd_addr, sig_addr, dbg_state}), 64'd0);
    check({tag, "_wdata"}, sig_wdata, 64'd0);
    check({tag, "_poly"}, 64'(|{poly0_o, poly1_o}), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vec_t rv;
    vecs[0] = '{3'd2, 8'h10, 0, 0,   1'b1, 1'b1, 256, 11, 1'b0, 272};
    vecs[1] = '{3'd3, 8'hFC, 0, 0,   1'b0, 1'b0, 384, 8,  1'b0, 397};
    vecs[2] = '{3'd5, 8'h20, 1, 302, 1'b0, 1'b0, 301, 0,  1'b1, 303};
    vecs[3] = '{3'd2, 8'h00, 2, 259, 1'b0, 1'b0, 256, 0,  1'b1, 261};
    vecs[4] = '{3'd7, 8'h80, 0, 0,   1'b0, 1'b0, 512, 11, 1'b0, 528};
    vecs[5] = '{3'd3, 8'h50, 3, 393, 1'b0, 1'b0, 384, 4,  1'b1, 394};

    // reset state
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 6; i++) run(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    // async reset in the middle of UNLOAD, after five writes
    @(posedge clk); #1;
    start = 1'b1; sec_lvl = 3'd2; sig_base = 8'h40; hint_valid_i = 1'b1; hint_i = 64'h5a5a;
    n = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      @(negedge clk);
      if (sig_we) n++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("midrun_writes", 64'(n), 64'd5);
    #2 rst = 1'b1;
    #1 check_all_zero("midrun_reset");
    hint_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rv = model(3'd2, 8'h33, 0, 0);
    run(rv, 1'b0, 1'b0, "post_reset");

`ifdef MAKEHINT_CTRL_SIGBP_EN
    // signature RAM backpressure: ready pattern 1,0,0,1,...
    rv = model(3'd3, 8'hFE, 0, 0);
    rv.end_cyc = -1;
    run(rv, 1'b0, 1'b1, "sig_bp");
`endif

    // randomized jobs against the job-level model
    for (int i = 0; i < 8; i++) begin
      bit rv_valid;
      rv = model(3'($urandom_range(0, 7)), SW'($urandom), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 511)));
      rv_valid = ($urandom_range(0, 1) == 1);
      if (rv_valid && rv.mode == 0) rv.end_cyc = -1;
      run(rv, rv_valid, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
